// File: rtl/alu_pkg.sv
// Shared encodings and constants for the iterative multiply/divide/shift unit.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_MUL = 3'd0,
    ALU_DIV = 3'd1,
    ALU_SHL = 3'd2,
    ALU_SHR = 3'd3,
    ALU_ROR = 3'd4
  } aluOp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] DIV0_QUOT     = 8'hFF;
  localparam int         MUL_DIV_ITERS = 8;

endpackage

// File: rtl/alu_iter_step.sv
// One iteration of the multicycle ALU datapath; purely combinational.
// MUL: {accHi,accLo} is the product/multiplier shift pair. DIV: accHi=remainder, accLo=dividend/quotient.
module alu_iter_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] accHi,
  input  logic [WIDTH-1:0] accLo,
  input  logic [WIDTH-1:0] aux,
  input  logic             flag,
  output logic [WIDTH-1:0] nextHi,
  output logic [WIDTH-1:0] nextLo,
  output logic             nextFlag
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;

  always_comb begin
    nextHi   = accHi;
    nextLo   = accLo;
    nextFlag = flag;
    sum      = {1'b0, accHi} + (accLo[0] ? {1'b0, aux} : '0);
    shifted  = {accHi, accLo[WIDTH-1]};
    case (op)
      ALU_MUL: begin
        nextHi = sum[WIDTH:1];
        nextLo = {sum[0], accLo[WIDTH-1:1]};
      end
      ALU_DIV: begin
        // Remainder stays below the divisor, so shifted always fits WIDTH+1 bits.
        if (shifted >= {1'b0, aux}) begin
          nextHi = shifted[WIDTH-1:0] - aux;
          nextLo = {accLo[WIDTH-2:0], 1'b1};
        end else begin
          nextHi = shifted[WIDTH-1:0];
          nextLo = {accLo[WIDTH-2:0], 1'b0};
        end
      end
      ALU_SHL: begin
        nextFlag = accLo[WIDTH-1];
        nextLo   = {accLo[WIDTH-2:0], 1'b0};
      end
      ALU_SHR: begin
        nextFlag = accLo[0];
        nextLo   = {1'b0, accLo[WIDTH-1:1]};
      end
      ALU_ROR: begin
        nextFlag = accLo[0];
        nextLo   = {flag, accLo[WIDTH-1:1]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_alu.sv
// Iterative MUL/DIV/shift unit: done in cycle N+1 after start, busy while iterating, start ignored in CALC.
// MULTICYCLE_ALU_PERF_EN adds a saturating stallCycles counter of busy cycles.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             flagin,
  output logic             busy,
  output logic             done,
  output logic             writeEn,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] resultHi,
  output logic             flagout
`ifdef MULTICYCLE_ALU_PERF_EN
  ,
  output logic [15:0]      stallCycles
`endif
);

  state_t           state, stateNext;
  logic [CNT_W-1:0] cnt, loadCnt;
  logic [2:0]       opR;
  logic [WIDTH-1:0] accHi, accLo, aux;
  logic             flagR;
  logic [WIDTH-1:0] stepHi, stepLo;
  logic             stepFlag;
  logic [WIDTH-1:0] loadLo, loadAux, zeroLo, zeroHi, finLo, finHi;
  logic             loadFlag, zeroFlag, finFlag, accept;

  alu_iter_step #(.WIDTH(WIDTH)) uStep (
    .op      (opR),
    .accHi   (accHi),
    .accLo   (accLo),
    .aux     (aux),
    .flag    (flagR),
    .nextHi  (stepHi),
    .nextLo  (stepLo),
    .nextFlag(stepFlag)
  );

  assign accept  = start && (state != CALC);
  assign busy    = (state == CALC);
  assign done    = (state == DONE);
  assign writeEn = done;

  // Iteration count, initial accumulators, and the result used when no iteration is needed.
  always_comb begin
    loadCnt  = '0;
    loadLo   = opA;
    loadAux  = opB;
    loadFlag = 1'b0;
    zeroLo   = opA;
    zeroHi   = '0;
    zeroFlag = 1'b0;
    case (op)
      ALU_MUL: begin
        loadCnt = CNT_W'(MUL_DIV_ITERS);
        loadLo  = opB;
        loadAux = opA;
      end
      ALU_DIV: begin
        if (opB != '0) loadCnt = CNT_W'(MUL_DIV_ITERS);
        zeroLo   = DIV0_QUOT;
        zeroHi   = opA;
        zeroFlag = 1'b1;
      end
      ALU_SHL, ALU_SHR: loadCnt = CNT_W'(opB[2:0]);
      ALU_ROR: begin
        loadCnt  = CNT_W'(opB[2:0]);
        loadFlag = flagin;
        zeroFlag = flagin;
      end
      default: zeroFlag = flagin;
    endcase
  end

  always_comb begin
    finLo   = stepLo;
    finHi   = '0;
    finFlag = stepFlag;
    case (opR)
      ALU_MUL: begin
        finHi   = stepHi;
        finFlag = |stepHi;
      end
      ALU_DIV: begin
        finHi   = stepHi;
        finFlag = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE, DONE: begin
        if (start) stateNext = (loadCnt == '0) ? DONE : CALC;
        else       stateNext = IDLE;
      end
      CALC:    if (cnt == CNT_W'(1)) stateNext = DONE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      opR      <= '0;
      accHi    <= '0;
      accLo    <= '0;
      aux      <= '0;
      flagR    <= 1'b0;
      result   <= '0;
      resultHi <= '0;
      flagout  <= 1'b0;
    end else begin
      state <= stateNext;
      if (accept) begin
        opR   <= op;
        cnt   <= loadCnt;
        accHi <= '0;
        accLo <= loadLo;
        aux   <= loadAux;
        flagR <= loadFlag;
        if (loadCnt == '0) begin
          result   <= zeroLo;
          resultHi <= zeroHi;
          flagout  <= zeroFlag;
        end
      end else if (state == CALC) begin
        cnt   <= cnt - CNT_W'(1);
        accHi <= stepHi;
        accLo <= stepLo;
        flagR <= stepFlag;
        if (cnt == CNT_W'(1)) begin
          result   <= finLo;
          resultHi <= finHi;
          flagout  <= finFlag;
        end
      end
    end
  end

`ifdef MULTICYCLE_ALU_PERF_EN
  logic [15:0] stallCnt;

  always_ff @(posedge CLK) begin
    if (reset)                            stallCnt <= '0;
    else if (busy && stallCnt != 16'hFFFF) stallCnt <= stallCnt + 16'd1;
  end

  assign stallCycles = stallCnt;
`endif

endmodule

// File: tb/tb_multicycle_alu.sv
// Randomized self-checking bench for multicycle_alu against an arithmetic reference model.
module tb_multicycle_alu;

  logic       CLK = 1'b0;
  logic       reset, start, flagin;
  logic [2:0] op;
  logic [7:0] opA, opB;
  logic       busy, done, writeEn, flagout;
  logic [7:0] result, resultHi;
`ifdef MULTICYCLE_ALU_PERF_EN
  logic [15:0] stallCycles;
  int          expStall = 0;
`endif

  int         checks = 0;
  int         errors = 0;
  logic [7:0] expLo = '0, expHi = '0;
  logic       expFlag = 1'b0;

  always #5 CLK = ~CLK;

  multicycle_alu dut (
    .CLK     (CLK),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .opA     (opA),
    .opB     (opB),
    .flagin  (flagin),
    .busy    (busy),
    .done    (done),
    .writeEn (writeEn),
    .result  (result),
    .resultHi(resultHi),
    .flagout (flagout)
`ifdef MULTICYCLE_ALU_PERF_EN
    ,
    .stallCycles(stallCycles)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Returns {n[31:24], flag[16], hi[15:8], lo[7:0]} straight from the arithmetic definition.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [7:0] a,
                                        input logic [7:0] b, input logic f);
    int ia, ib, ifl, n, lo, hi, fl, v;
    ia = int'(a); ib = int'(b); ifl = int'(f);
    n = 0; lo = ia; hi = 0; fl = ifl;
    case (o)
      3'd0: begin n = 8; lo = (ia * ib) % 256; hi = (ia * ib) / 256; fl = (hi != 0) ? 1 : 0; end
      3'd1: begin
        if (ib == 0) begin lo = 255; hi = ia; fl = 1; end
        else begin n = 8; lo = ia / ib; hi = ia % ib; fl = 0; end
      end
      3'd2: begin n = ib % 8; lo = (ia << n) % 256; fl = (n == 0) ? 0 : (ia >> (8 - n)) % 2; end
      3'd3: begin n = ib % 8; lo = ia >> n; fl = (n == 0) ? 0 : (ia >> (n - 1)) % 2; end
      3'd4: begin
        n  = ib % 8;
        v  = ifl * 256 + ia;
        v  = ((v >> n) | (v << (9 - n))) % 512;
        lo = v % 256;
        fl = v / 256;
      end
      default: ;
    endcase
    return 32'((n << 24) | (fl << 16) | (hi << 8) | lo);
  endfunction

  task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b, input logic f);
    op = o; opA = a; opB = b; flagin = f; start = 1'b1;
  endtask

  // Call #1 after a rising edge; returns #1 after the DONE edge (or one idle cycle later).
  task automatic runOp(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                       input logic f, input bit idleAfter);
    logic [31:0] m;
    int n;
    m = model(o, a, b, f);
    n = int'(m[27:24]);
    issue(o, a, b, f);
    for (int k = 1; k <= n + 1; k++) begin
      @(posedge CLK); #1;
      if (k == 1) start = 1'b0;
      if (k <= n) begin
        check("busy", 32'(busy), 32'd1);
        check("doneEarly", 32'(done), 32'd0);
        check("holdCalc", {15'd0, flagout, resultHi, result}, {15'd0, expFlag, expHi, expLo});
      end else begin
        expLo = m[7:0]; expHi = m[15:8]; expFlag = m[16];
        check("busyDone", 32'(busy), 32'd0);
        check("done", 32'(done), 32'd1);
        check("writeEn", 32'(writeEn), 32'd1);
        check("result", 32'(result), 32'(expLo));
        check("resultHi", 32'(resultHi), 32'(expHi));
        check("flagout", 32'(flagout), 32'(expFlag));
`ifdef MULTICYCLE_ALU_PERF_EN
        expStall += n;
        check("stallCycles", 32'(stallCycles), 32'(expStall));
`endif
      end
    end
    if (idleAfter) begin
      @(posedge CLK); #1;
      check("doneOnce", 32'(done), 32'd0);
      check("idleBusy", 32'(busy), 32'd0);
      check("holdIdle", {15'd0, flagout, resultHi, result}, {15'd0, expFlag, expHi, expLo});
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; opA = '0; opB = '0; flagin = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rstState", {24'd0, busy, done, writeEn, flagout, 4'd0}, 32'd0);
    check("rstData", {16'd0, resultHi, result}, 32'd0);
`ifdef MULTICYCLE_ALU_PERF_EN
    check("rstStall", 32'(stallCycles), 32'd0);
`endif
    reset = 1'b0;
    @(posedge CLK); #1;

    runOp(3'd0, 8'h0D, 8'h0B, 1'b0, 1'b1);
    check("mul13x11", {15'd0, flagout, resultHi, result}, 32'h0000_008F);
    runOp(3'd0, 8'hFF, 8'hFF, 1'b0, 1'b0);
    runOp(3'd1, 8'h64, 8'h07, 1'b0, 1'b1);
    check("div100by7", {15'd0, flagout, resultHi, result}, 32'h0000_020E);
    runOp(3'd1, 8'h64, 8'h00, 1'b0, 1'b1);
    check("div0", {15'd0, flagout, resultHi, result}, 32'h0001_64FF);
    runOp(3'd3, 8'h81, 8'h03, 1'b0, 1'b1);
    runOp(3'd2, 8'h81, 8'h01, 1'b0, 1'b1);
    check("shl1", {15'd0, flagout, resultHi, result}, 32'h0001_0002);
    runOp(3'd2, 8'h5A, 8'h08, 1'b1, 1'b1);
    runOp(3'd4, 8'h01, 8'h01, 1'b0, 1'b1);
    check("ror1", {15'd0, flagout, resultHi, result}, 32'h0001_0000);
    runOp(3'd7, 8'h3C, 8'h00, 1'b1, 1'b1);
    runOp(3'd4, 8'hA5, 8'h07, 1'b1, 1'b0);
    runOp(3'd5, 8'hC3, 8'h11, 1'b0, 1'b1);

    for (int i = 0; i < 60; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if ($urandom_range(0, 7) == 0) b = '0;
      runOp(3'($urandom_range(0, 7)), 8'($urandom), b, 1'($urandom), 1'($urandom));
    end

    // Abort: start re-pulsed mid-CALC is ignored, reset in cycle 5 kills the operation.
    issue(3'd0, 8'h12, 8'h34, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(posedge CLK); #1;
      if (k == 1) start = 1'b0;
      if (k == 3) start = 1'b1;
      if (k == 4) start = 1'b0;
      check("abortBusy", 32'(busy), 32'd1);
      if (k == 5) reset = 1'b1;
    end
    @(posedge CLK); #1;
    reset = 1'b0;
    expLo = '0; expHi = '0; expFlag = 1'b0;
    check("abortState", {28'd0, busy, done, writeEn, flagout}, 32'd0);
    check("abortData", {16'd0, resultHi, result}, 32'd0);
`ifdef MULTICYCLE_ALU_PERF_EN
    expStall = 0;
    check("abortStall", 32'(stallCycles), 32'd0);
`endif
    for (int k = 0; k < 8; k++) begin
      @(posedge CLK); #1;
      check("abortNoDone", {30'd0, done, busy}, 32'd0);
    end
    runOp(3'd0, 8'h0D, 8'h0B, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
